dmi_arbiter: RTL and testbench
==============================

Name: dmi_arbiter

Overview:
- Core-domain arbiter sharing the single Debug Module DMI port between NumReq requesters, e.g. the CDC'd JTAG DTM path and an on-chip debug mailbox.
- Grants round-robin, keeps exactly one transaction outstanding, and routes the DM response back to the owning requester.
- Aborts cleanly on the DMI clear pulse and returns a failure response if the DM does not answer within TimeoutCycles.

Parameters:
- NumReq, 2, number of requesters (>=2).
- TimeoutCycles, 1024, clk_i cycles allowed between DM request acceptance and DM response (>=2).
- IdxW, $clog2(NumReq), derived owner index width.

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  asynchronous active-low reset.
- dmi_clear_ni  in  1  synchronous active-low one-cycle clear pulse from the DMI CDC.
- req_i  in  NumReq x dmi_req_t (addr 7, op 2, data 32 = 41b)  requester payloads.
- req_valid_i  in  NumReq  requester valids.
- req_ready_o  out  NumReq  requester readies.
- resp_o  out  dmi_resp_t (data 32, resp 2 = 34b)  shared response payload.
- resp_valid_o  out  NumReq  one-hot response valid to the owner.
- resp_ready_i  in  NumReq  requester response readies.
- dm_req_o  out  dmi_req_t  request to DM.
- dm_req_valid_o  out  1  request valid to DM.
- dm_req_ready_i  in  1  DM request ready.
- dm_resp_i  in  dmi_resp_t  DM response.
- dm_resp_valid_i  in  1  DM response valid.
- dm_resp_ready_o  out  1  DM response ready.
- busy_o  out  1  high whenever the FSM is not IDLE.
- owner_o  out  IdxW  index of the current or last owner.
- timeout_o  out  1  one-cycle pulse when a timeout fires.

Behaviour:
- Reset values: all outputs 0; rr pointer = 0; FSM = IDLE; payload registers = 0.
- FSM states: IDLE, REQ, WAIT, RSP.
- IDLE:
  - Winner = first i with req_valid_i[i]=1, searching from the rr pointer upward with wrap.
  - req_ready_o[winner]=1 combinationally; all other req_ready_o = 0.
  - On the handshake: latch req_i[winner] into the request register, owner <= winner, rr <= winner+1 mod NumReq, go to REQ.
  - If no requester is valid, stay in IDLE; rr is unchanged.
- REQ:
  - dm_req_valid_o=1 and dm_req_o = latched request, held stable until dm_req_ready_i.
  - On the handshake: timeout counter <= 0, go to WAIT.
- WAIT:
  - dm_resp_ready_o=1; the counter increments each cycle.
  - On dm_resp_valid_i: latch dm_resp_i, go to RSP.
  - Else if counter == TimeoutCycles-1: latch {data=0, resp=2'b10}, pulse timeout_o, go to RSP.
  - If a response and the timeout coincide, the response wins and timeout_o stays low.
- RSP:
  - resp_valid_o[owner]=1 with resp_o = latched response.
  - On resp_ready_i[owner]: go to IDLE.
- Latency: first DM request cycle is 1 cycle after the requester handshake. Response is visible at the requester 1 cycle after the DM response handshake.
- Strays: in IDLE, REQ and RSP, dm_resp_ready_o=1 and any dm_resp_valid_i is discarded (DM response arriving after a clear or timeout).
- dmi_clear_ni=0 in any state:
  - Next state IDLE; counter cleared; rr preserved.
  - req_ready_o forced 0 that cycle, so no grant.
  - Any in-flight response is dropped without resp_valid_o.
- Reset mid-operation: immediate return to reset values; no partial handshake completes.
- resp_o is driven only while in RSP, otherwise 0. owner_o holds its last value in IDLE.

Test Plan:
- Single request, NumReq=2:
  - Stimulus: req 1 {addr=0x10, op=2 (write), data=0xDEADBEEF}; DM ready immediately; response {0x0, 0} after 3 cycles.
  - Required: dm_req_valid_o 1 cycle after the grant; resp_valid_o=2'b10 with resp=0.
- Fairness:
  - Stimulus: both requesters hold valid for 4 transactions.
  - Required: grant order 0,1,0,1; owner_o matches each grant.
- DM backpressure:
  - Stimulus: dm_req_ready_i low for 5 cycles.
  - Required: dm_req_o stays stable and dm_req_valid_o stays high, with no extra grants, until the handshake.
- Timeout, TimeoutCycles=8:
  - Stimulus: no DM response.
  - Required: timeout_o pulses 8 cycles after the DM handshake; owner receives {data=0, resp=2'b10}.
  - Follow-up: a late DM response arrives in IDLE; it is consumed and no resp_valid_o is raised.
- Clear in WAIT:
  - Stimulus: dmi_clear_ni=0 for 1 cycle.
  - Required: FSM returns to IDLE and busy_o drops the next cycle; no resp_valid_o; the next request is granted normally.
- Simultaneous events:
  - Stimulus: DM response valid in the same cycle the counter hits TimeoutCycles-1.
  - Required: the real response is forwarded and timeout_o stays 0.

Source files
------------

// File: rtl/dmi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmi_arbiter
// Purpose  : Shares the single Debug Module DMI port between NumReq requesters.
//            Round-robin grant, exactly one transaction in flight, response
//            routed back to the owner, clean abort on DMI clear, and a
//            synthesized failure response if the DM stays silent too long.
//            Payloads: request {addr[40:34], op[33:32], data[31:0]},
//                      response {data[33:2], resp[1:0]}.
// Revision : 1.0 - initial release
// ============================================================================
module dmi_arbiter #(
  parameter int NumReq        = 2,
  parameter int TimeoutCycles = 1024,
  parameter int IdxW          = $clog2(NumReq)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     dmi_clear_ni,
  input  logic [NumReq-1:0][40:0]  req_i,
  input  logic [NumReq-1:0]        req_valid_i,
  output logic [NumReq-1:0]        req_ready_o,
  output logic [33:0]              resp_o,
  output logic [NumReq-1:0]        resp_valid_o,
  input  logic [NumReq-1:0]        resp_ready_i,
  output logic [40:0]              dm_req_o,
  output logic                     dm_req_valid_o,
  input  logic                     dm_req_ready_i,
  input  logic [33:0]              dm_resp_i,
  input  logic                     dm_resp_valid_i,
  output logic                     dm_resp_ready_o,
  output logic                     busy_o,
  output logic [IdxW-1:0]          owner_o,
  output logic                     timeout_o
);

  localparam int CNT_W = $clog2(TimeoutCycles);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RSP  = 2'd3;

  // Failure response handed to the owner when the DM never answers.
  localparam logic [33:0]      TIMEOUT_RESP = {32'h0, 2'b10};
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(TimeoutCycles - 1);

  logic [1:0]       state_q, state_d;
  logic [40:0]      req_q;
  logic [33:0]      resp_q;
  logic [IdxW-1:0]  owner_q;
  logic [IdxW-1:0]  rr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rdy_q;

  logic             win_found;
  logic [IdxW-1:0]  win_idx;
  logic [IdxW-1:0]  win_next;
  logic             grant;
  logic             to_fire;
  int unsigned      cand;

  // Round-robin search: first valid requester at or above the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NumReq; k++) begin
      cand = (int'(rr_q) + k) % NumReq;
      if (!win_found && req_valid_i[cand]) begin
        win_found = 1'b1;
        win_idx   = IdxW'(cand);
      end
    end
  end

  assign win_next = (win_idx == IdxW'(NumReq - 1)) ? '0 : win_idx + 1'b1;
  // A clear cycle never grants, so the aborting side cannot race a new owner in.
  assign grant    = (state_q == ST_IDLE) && dmi_clear_ni && win_found;
  // Silence on the last allowed cycle; a coincident real response wins.
  assign to_fire  = (state_q == ST_WAIT) && !dm_resp_valid_i && (cnt_q == CNT_LAST);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the DMI clear overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant)                  state_d = ST_REQ;
      ST_REQ:  if (dm_req_ready_i)         state_d = ST_WAIT;
      ST_WAIT: if (dm_resp_valid_i || to_fire) state_d = ST_RSP;
      ST_RSP:  if (resp_ready_i[owner_q])  state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
    if (!dmi_clear_ni) state_d = ST_IDLE;
  end

  // Output decode from the current state.
  always_comb begin
    req_ready_o  = '0;
    resp_valid_o = '0;
    if (grant) req_ready_o[win_idx] = 1'b1;
    if ((state_q == ST_RSP) && dmi_clear_ni) resp_valid_o[owner_q] = 1'b1;
    dm_req_valid_o  = (state_q == ST_REQ);
    dm_req_o        = (state_q == ST_REQ) ? req_q : '0;
    resp_o          = (state_q == ST_RSP) ? resp_q : '0;
    busy_o          = (state_q != ST_IDLE);
    owner_o         = owner_q;
    dm_resp_ready_o = rdy_q;
    timeout_o       = to_fire && dmi_clear_ni;
  end

  // Payload, ownership, round-robin pointer and response-timeout counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q   <= '0;
      resp_q  <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      // Responses are always accepted out of reset; strays are simply dropped.
      rdy_q <= 1'b1;
      if (!dmi_clear_ni) begin
        cnt_q <= '0;
      end else begin
        if (grant) begin
          req_q   <= req_i[win_idx];
          owner_q <= win_idx;
          rr_q    <= win_next;
        end
        if ((state_q == ST_REQ) && dm_req_ready_i) cnt_q <= '0;
        if (state_q == ST_WAIT) begin
          cnt_q <= cnt_q + 1'b1;
          if (dm_resp_valid_i) resp_q <= dm_resp_i;
          else if (to_fire)    resp_q <= TIMEOUT_RESP;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmi_arbiter
// Purpose  : Self-checking bench for dmi_arbiter (NumReq=2, TimeoutCycles=8):
//            table vectors, directed corner sequences and random traffic
//            against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmi_arbiter;
  localparam int N = 2;
  localparam int T = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clr_n;
  logic [N-1:0][40:0] req;
  logic [N-1:0]      req_valid, req_ready, resp_valid, resp_ready;
  logic [33:0]       resp, dm_resp;
  logic [40:0]       dm_req;
  logic              dm_req_valid, dm_req_ready, dm_resp_valid, dm_resp_ready;
  logic              busy, timeout;
  logic [0:0]        owner;

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 idle, 1 request to DM, 2 awaiting DM, 3 answering.
  int          ph, m_last, m_owner, m_deadline, cyc;
  logic [40:0] m_req;
  logic [33:0] m_resp;
  logic        m_rdy;

  dmi_arbiter #(.NumReq(N), .TimeoutCycles(T)) dut (
    .clk_i(clk), .rst_ni(rst_n), .dmi_clear_ni(clr_n),
    .req_i(req), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .resp_o(resp), .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .dm_req_o(dm_req), .dm_req_valid_o(dm_req_valid), .dm_req_ready_i(dm_req_ready),
    .dm_resp_i(dm_resp), .dm_resp_valid_i(dm_resp_valid), .dm_resp_ready_o(dm_resp_ready),
    .busy_o(busy), .owner_o(owner), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [83:0] dut_out();
    return {req_ready, dm_req_valid, dm_req, dm_resp_ready, resp_valid, resp, busy, owner, timeout};
  endfunction

  // Next owner under round robin: nearest valid requester after the last owner.
  function automatic int m_winner();
    for (int d = 1; d <= N; d++) begin
      if (req_valid[(m_last + d) % N]) return (m_last + d) % N;
    end
    return -1;
  endfunction

  function automatic logic [83:0] m_out();
    logic [1:0] er, erv;
    logic       eto;
    int         w;
    w   = m_winner();
    er  = '0;
    erv = '0;
    if (ph == 0 && clr_n && w >= 0) er[w] = 1'b1;
    if (ph == 3 && clr_n) erv[m_owner] = 1'b1;
    eto = (ph == 2) && clr_n && !dm_resp_valid && (cyc == m_deadline);
    return {er, (ph == 1), (ph == 1) ? m_req : 41'h0, m_rdy, erv,
            (ph == 3) ? m_resp : 34'h0, (ph != 0), 1'(m_owner), eto};
  endfunction

  task automatic m_update();
    int w;
    w = m_winner();
    if (!clr_n) ph = 0;
    else begin
      case (ph)
        0: if (w >= 0) begin m_req = req[w]; m_owner = w; m_last = w; ph = 1; end
        1: if (dm_req_ready) begin m_deadline = cyc + T; ph = 2; end
        2: if (dm_resp_valid) begin m_resp = dm_resp; ph = 3; end
           else if (cyc == m_deadline) begin m_resp = {32'h0, 2'b10}; ph = 3; end
        default: if (resp_ready[m_owner]) ph = 0;
      endcase
    end
    m_rdy = 1'b1;
    cyc++;
  endtask

  // One clock: compare every output against the model, then advance both.
  task automatic tick();
    #2;
    chk("cycle", 128'(dut_out()), 128'(m_out()));
    m_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0; dm_req_ready = 1'b0; dm_resp_valid = 1'b0;
    dm_resp = '0; resp_ready = '0; clr_n = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("reset_outputs", 128'(dut_out()), 128'h0);
    ph = 0; m_last = N - 1; m_owner = 0; m_deadline = 0; cyc = 0;
    m_req = '0; m_resp = '0; m_rdy = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic finish_txn();
    int n;
    n = 0;
    req_valid = '0; dm_req_ready = 1'b1; dm_resp_valid = 1'b1; resp_ready = '1;
    while (ph != 0 && n < 20) begin tick(); n++; end
    idle_inputs();
    #1;
    chk("txn_done_busy", 128'(busy), 128'h0);
  endtask

  typedef struct {
    logic [1:0]  vld;
    logic        dmrdy;
    logic        dmrv;
    logic [33:0] dmr;
    logic [1:0]  rr;
    logic [1:0]  e_rdy;
    logic        e_dmv;
    logic [40:0] e_dmreq;
    logic [1:0]  e_rv;
    logic [33:0] e_resp;
    logic        e_busy;
  } vec_t;

  function automatic vec_t mk(logic [1:0] vld, logic dmrdy, logic dmrv, logic [33:0] dmr,
                              logic [1:0] rr, logic [1:0] e_rdy, logic e_dmv, logic [40:0] e_dmreq,
                              logic [1:0] e_rv, logic [33:0] e_resp, logic e_busy);
    vec_t v;
    v.vld = vld; v.dmrdy = dmrdy; v.dmrv = dmrv; v.dmr = dmr; v.rr = rr;
    v.e_rdy = e_rdy; v.e_dmv = e_dmv; v.e_dmreq = e_dmreq; v.e_rv = e_rv;
    v.e_resp = e_resp; v.e_busy = e_busy;
    return v;
  endfunction

  initial begin
    logic [40:0] p0, p1, saved;
    logic [33:0] r2, rs;
    vec_t        tbl[14];
    int          h, tk, g, gi;

    p1 = {7'h10, 2'd2, 32'hDEADBEEF};
    p0 = {7'h22, 2'd1, 32'h0000_0000};
    r2 = {32'h1234_5678, 2'b00};
    rs = {32'hCAFE_F00D, 2'b01};
    req[0] = p0; req[1] = p1;

    //            vld   rdy  rv  dmr    rr     e_rdy e_dmv e_dmreq e_rv  e_resp e_busy
    tbl[0]  = mk(2'b10, 1, 0, 34'h0, 2'b00, 2'b10, 0, 41'h0, 2'b00, 34'h0, 0);
    tbl[1]  = mk(2'b00, 1, 0, 34'h0, 2'b00, 2'b00, 1, p1,    2'b00, 34'h0, 1);
    tbl[2]  = mk(2'b00, 0, 0, 34'h0, 2'b00, 2'b00, 0, 41'h0, 2'b00, 34'h0, 1);
    tbl[3]  = mk(2'b00, 0, 0, 34'h0, 2'b00, 2'b00, 0, 41'h0, 2'b00, 34'h0, 1);
    tbl[4]  = mk(2'b00, 0, 1, 34'h0, 2'b00, 2'b00, 0, 41'h0, 2'b00, 34'h0, 1);
    tbl[5]  = mk(2'b00, 0, 0, 34'h0, 2'b11, 2'b00, 0, 41'h0, 2'b10, 34'h0, 1);
    tbl[6]  = mk(2'b00, 0, 0, 34'h0, 2'b00, 2'b00, 0, 41'h0, 2'b00, 34'h0, 0);
    tbl[7]  = mk(2'b01, 0, 0, 34'h0, 2'b00, 2'b01, 0, 41'h0, 2'b00, 34'h0, 0);
    tbl[8]  = mk(2'b00, 0, 0, 34'h0, 2'b00, 2'b00, 1, p0,    2'b00, 34'h0, 1);
    tbl[9]  = mk(2'b00, 1, 0, 34'h0, 2'b00, 2'b00, 1, p0,    2'b00, 34'h0, 1);
    tbl[10] = mk(2'b00, 0, 1, r2,    2'b00, 2'b00, 0, 41'h0, 2'b00, 34'h0, 1);
    tbl[11] = mk(2'b00, 0, 0, 34'h0, 2'b00, 2'b00, 0, 41'h0, 2'b01, r2,    1);
    tbl[12] = mk(2'b00, 0, 0, 34'h0, 2'b01, 2'b00, 0, 41'h0, 2'b01, r2,    1);
    tbl[13] = mk(2'b00, 0, 0, 34'h0, 2'b00, 2'b00, 0, 41'h0, 2'b00, 34'h0, 0);

    rst_n = 1'b0;
    do_reset();

    // Table vectors: single request from requester 1, then one from requester 0.
    for (int i = 0; i < 14; i++) begin
      req_valid = tbl[i].vld; dm_req_ready = tbl[i].dmrdy; dm_resp_valid = tbl[i].dmrv;
      dm_resp = tbl[i].dmr; resp_ready = tbl[i].rr;
      #2;
      chk($sformatf("tbl%0d", i),
          128'({req_ready, dm_req_valid, dm_req, resp_valid, resp, busy}),
          128'({tbl[i].e_rdy, tbl[i].e_dmv, tbl[i].e_dmreq, tbl[i].e_rv, tbl[i].e_resp, tbl[i].e_busy}));
      tick();
    end

    // Fairness: both requesters always valid, grants alternate from requester 0.
    do_reset();
    req_valid = 2'b11; dm_req_ready = 1'b1; dm_resp_valid = 1'b1; resp_ready = 2'b11;
    g = 0;
    for (int c = 0; c < 40 && g < 4; c++) begin
      #1;
      if (req_ready != 2'b00) begin
        gi = int'(req_ready[1]);
        chk($sformatf("grant%0d", g), 128'(gi), 128'(g % 2));
        tick();
        chk($sformatf("owner%0d", g), 128'(owner), 128'(g % 2));
        g++;
      end else begin
        tick();
      end
    end
    chk("fair_grants", 128'(g), 128'd4);
    finish_txn();

    // DM backpressure: payload must hold even if the requester's data changes.
    req[0] = p0; req_valid = 2'b01;
    tick();
    req_valid = 2'b11; req[0] = {7'h7F, 2'd3, 32'h5555_AAAA};
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_valid", 128'(dm_req_valid), 128'h1);
      chk("bp_payload", 128'(dm_req), 128'(p0));
      chk("bp_no_grant", 128'(req_ready), 128'h0);
      tick();
    end
    dm_req_ready = 1'b1;
    tick();
    finish_txn();
    req[0] = p0;

    // Timeout: DM silent, failure response delivered, late response discarded.
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00; dm_req_ready = 1'b1; h = cyc;
    tick();
    dm_req_ready = 1'b0; tk = -1;
    for (int k = 1; k <= 12; k++) begin
      #1;
      if (timeout && tk < 0) tk = k;
      tick();
      if (tk >= 0) break;
    end
    chk("timeout_delay", 128'(tk), 128'(T));
    #1;
    chk("timeout_resp", 128'(resp), 128'({32'h0, 2'b10}));
    chk("timeout_rv", 128'(resp_valid), 128'h1);
    resp_ready = 2'b01;
    tick();
    resp_ready = 2'b00; dm_resp_valid = 1'b1; dm_resp = rs;
    #1;
    chk("late_rv", 128'(resp_valid), 128'h0);
    chk("late_ready", 128'(dm_resp_ready), 128'h1);
    tick();
    dm_resp_valid = 1'b0;
    #1;
    chk("late_rv2", 128'(resp_valid), 128'h0);
    tick();

    // Clear while waiting on the DM.
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00; dm_req_ready = 1'b1;
    tick();
    dm_req_ready = 1'b0;
    tick();
    tick();
    clr_n = 1'b0; req_valid = 2'b11;
    #1;
    chk("clr_no_grant", 128'(req_ready), 128'h0);
    tick();
    clr_n = 1'b1; req_valid = 2'b00;
    #1;
    chk("clr_busy", 128'(busy), 128'h0);
    for (int c = 0; c < 3; c++) begin
      dm_resp_valid = 1'b1; dm_resp = rs;
      #1;
      chk("clr_no_rv", 128'(resp_valid), 128'h0);
      tick();
    end
    dm_resp_valid = 1'b0; req_valid = 2'b01;
    #1;
    chk("clr_regrant", 128'(req_ready), 128'h1);
    tick();
    finish_txn();

    // Response arriving on the very cycle the timeout would fire.
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00; dm_req_ready = 1'b1; h = cyc;
    tick();
    dm_req_ready = 1'b0;
    while (cyc < h + T) tick();
    dm_resp_valid = 1'b1; dm_resp = rs;
    #1;
    chk("sim_no_timeout", 128'(timeout), 128'h0);
    tick();
    dm_resp_valid = 1'b0;
    #1;
    chk("sim_resp", 128'(resp), 128'(rs));
    chk("sim_rv", 128'(resp_valid), 128'h2);
    resp_ready = 2'b10;
    tick();
    idle_inputs();

    // Reset in the middle of a transaction.
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00; dm_req_ready = 1'b1;
    tick();
    dm_req_ready = 1'b0;
    tick();
    do_reset();
    tick();

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      req_valid     = 2'($urandom);
      req[0]        = {7'($urandom), 2'($urandom), 32'($urandom)};
      req[1]        = {7'($urandom), 2'($urandom), 32'($urandom)};
      dm_req_ready  = 1'($urandom_range(0, 1));
      dm_resp_valid = ($urandom_range(0, 9) == 0);
      dm_resp       = {32'($urandom), 2'($urandom)};
      resp_ready    = 2'($urandom);
      clr_n         = ($urandom_range(0, 99) >= 3);
      tick();
    end
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
